// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives pc into a 1-cycle-latency instruction memory,
// buffers returned words in a 2-entry FIFO, and hands them to decode via valid/ready.
module instruction_fetch #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input  logic              CLK_SYS,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t            state;
  state_t            state_next;
  logic              inflight;
  logic [ADDR_W-1:0] flight_pc;
  logic [DATA_W-1:0] fifo_instr [2];
  logic [ADDR_W-1:0] fifo_pc    [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              pop;
  logic              push;
  logic              halt_ret;
  logic              issue;
  logic [2:0]        occupancy;

  assign pop       = if_valid & if_ready;
  assign push      = inflight;
  assign halt_ret  = inflight && (instruction == HALT_WORD);
  // Slots already claimed after this edge's pop; pop never exceeds count.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      RUN: begin
        if (halt_ret) state_next = HALT_PEND;
        else          issue      = (occupancy < 3'd2);
      end
      HALT_PEND: begin
        if (count == 2'd0) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      flight_pc <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      // Decode owns the redirect: drop everything buffered or returning.
      state    <= RUN;
      pc       <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      state <= state_next;
      if (push) begin
        fifo_instr[wr_ptr] <= instruction;
        fifo_pc[wr_ptr]    <= flight_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        flight_pc <= pc;
        inflight  <= 1'b1;
        pc        <= pc + ADDR_W'(1);
      end else begin
        inflight  <= 1'b0;
      end
    end
  end

  assign if_valid = (count != 2'd0);
  assign if_instr = fifo_instr[rd_ptr];
  assign if_pc    = fifo_pc[rd_ptr];
  assign halted   = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a queue-based fetch model checked every cycle,
// plus directed scenarios with literal expectations (reset, backpressure, redirect, wrap, halt).
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int M_RUN    = 0;
  localparam int M_PEND   = 1;
  localparam int M_HALTED = 2;

  logic        CLK_SYS = 1'b0;
  logic        rst;
  logic [9:0]  pc;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;
  logic        halted;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } entry_t;

  entry_t     q[$];
  logic [9:0] m_pc;
  logic [9:0] m_fpc;
  logic       m_fl;
  int         m_mode;
  bit         model_ok = 1'b0;

  instruction_fetch dut (
    .CLK_SYS         (CLK_SYS),
    .rst             (rst),
    .pc              (pc),
    .instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .halted          (halted)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  // Instruction memory: samples pc at an edge, word valid during the following cycle.
  always @(posedge CLK_SYS) instruction <= mem[pc];

  // Behavioural fetch model: a queue of delivered words, one outstanding fetch, and a mode.
  always @(posedge CLK_SYS) begin
    automatic bit pop_m;
    automatic bit hw;
    automatic bit can;
    automatic bit pend_done;
    automatic int occ;
    automatic int mode_old;
    if (rst) begin
      q.delete();
      m_pc     = 10'h000;
      m_fpc    = 10'h000;
      m_fl     = 1'b0;
      m_mode   = M_RUN;
      model_ok = 1'b1;
    end else if (model_ok && redirect_valid) begin
      q.delete();
      m_fl   = 1'b0;
      m_pc   = redirect_target;
      m_mode = M_RUN;
    end else if (model_ok) begin
      mode_old  = m_mode;
      pop_m     = (q.size() != 0) && if_ready;
      hw        = m_fl && (mem[m_fpc] == HALT);
      pend_done = (m_mode == M_PEND) && (q.size() == 0);
      occ       = q.size() + int'(m_fl) - int'(pop_m);
      can       = (mode_old == M_RUN) && !hw && (occ < 2);
      if (pop_m) void'(q.pop_front());
      if (m_fl) q.push_back('{a: m_fpc, d: mem[m_fpc]});
      if (mode_old == M_RUN && hw) m_mode = M_PEND;
      else if (pend_done)          m_mode = M_HALTED;
      if (can) begin
        m_fpc = m_pc;
        m_fl  = 1'b1;
        m_pc  = m_pc + 10'd1;
      end else begin
        m_fl  = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge CLK_SYS) begin
    if (model_ok) begin
      checkOutput("model_pc", 32'(pc), 32'(m_pc));
      checkOutput("model_if_valid", 32'(if_valid), 32'(q.size() != 0));
      checkOutput("model_halted", 32'(halted), 32'(m_mode == M_HALTED));
      if (q.size() != 0) begin
        checkOutput("model_if_pc", 32'(if_pc), 32'(q[0].a));
        checkOutput("model_if_instr", if_instr, q[0].d);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [9:0] tgt);
    rst             = r;
    if_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic runResetStream();
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    checkOutput("reset_pc", 32'(pc), 32'h0);
    checkOutput("reset_if_valid", 32'(if_valid), 32'h0);
    checkOutput("reset_if_pc", 32'(if_pc), 32'h0);
    checkOutput("reset_if_instr", if_instr, 32'h0);
    checkOutput("reset_halted", 32'(halted), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("first_edge_valid", 32'(if_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("second_edge_valid", 32'(if_valid), 32'h1);
    checkOutput("stream_pc0", 32'(if_pc), 32'h0);
    checkOutput("stream_instr0", if_instr, 32'hA000_0000);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
      checkOutput("stream_pc", 32'(if_pc), 32'(k));
      checkOutput("stream_instr", if_instr, 32'hA000_0000 | 32'(k));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 10'h000;
    if_ready        = 1'b1;

    $display("[TB] reset and streaming");
    runResetStream();

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    checkOutput("bp_pc_stalled", 32'(pc), 32'h2);
    checkOutput("bp_valid", 32'(if_valid), 32'h1);
    checkOutput("bp_if_pc", 32'(if_pc), 32'h0);
    checkOutput("bp_instr", if_instr, 32'hA000_0000);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
      checkOutput("bp_release_pc", 32'(if_pc), 32'(k));
    end

    $display("[TB] redirect");
    for (int i = 0; i < 50 && !(if_valid && if_pc == 10'h005); i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("wait_if_pc5", 32'(if_pc), 32'h5);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h100);
    checkOutput("redir_flush_valid", 32'(if_valid), 32'h0);
    checkOutput("redir_pc", 32'(pc), 32'h100);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("redir_if_pc", 32'(if_pc), 32'h100);
    checkOutput("redir_instr", if_instr, 32'hA000_0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("redir_next_pc", 32'(if_pc), 32'h101);

    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FE);
    checkOutput("wrap_pc", 32'(pc), 32'h3FE);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("wrap_if_pc_3fe", 32'(if_pc), 32'h3FE);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("wrap_if_pc_3ff", 32'(if_pc), 32'h3FF);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("wrap_if_pc_000", 32'(if_pc), 32'h000);
    checkOutput("wrap_instr_000", if_instr, 32'hA000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("wrap_if_pc_001", 32'(if_pc), 32'h001);

    $display("[TB] halt");
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    mem[3] = HALT;
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("halt_if_pc2", 32'(if_pc), 32'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("halt_if_pc3", 32'(if_pc), 32'h3);
    checkOutput("halt_word", if_instr, HALT);
    checkOutput("halt_not_yet", 32'(halted), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("halt_drained", 32'(if_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("halted_set", 32'(halted), 32'h1);
    checkOutput("halted_pc", 32'(pc), 32'h4);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
      checkOutput("halted_no_valid", 32'(if_valid), 32'h0);
      checkOutput("halted_pc_hold", 32'(pc), 32'h4);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h000);
    checkOutput("unhalt", 32'(halted), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("restart_if_pc", 32'(if_pc), 32'h0);
    checkOutput("restart_instr", if_instr, 32'hA000_0000);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000);
    mem[3] = 32'hA000_0003;
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    checkOutput("mid_pre_valid", 32'(if_valid), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    checkOutput("mid_reset_valid", 32'(if_valid), 32'h0);
    checkOutput("mid_reset_pc", 32'(pc), 32'h0);
    runResetStream();

    $display("[TB] redirect colliding with halt word");
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    mem[2] = HALT;
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h010);
    checkOutput("collide_halted", 32'(halted), 32'h0);
    checkOutput("collide_valid", 32'(if_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("collide_if_pc", 32'(if_pc), 32'h010);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    checkOutput("collide_next_pc", 32'(if_pc), 32'h011);
    checkOutput("collide_next_instr", if_instr, 32'hA000_0011);

    @(negedge CLK_SYS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
